// File: rtl/data_mem_responder.sv
// data_mem_responder
// Load/store responder for the core's data side. A request is latched in IDLE,
// held for a fixed number of wait states, then answered with a one-cycle
// Ready pulse. Err qualifies Ready when the access is rejected. The RAM is
// word-organised and little-endian, built from four byte-lane arrays with
// registered reads. Byte, half and word accesses are supported.
`timescale 1ns/1ps
module data_mem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic [2:0]  Funct3,
    output logic [31:0] ReadData,
    output logic        Ready,
    output logic        Err,
    output logic        Busy
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t         state_reg, state_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic [31:0]    addr_reg, addr_next;
    logic [31:0]    wdata_reg, wdata_next;
    logic [2:0]     f3_reg, f3_next;
    logic           rd_reg, rd_next;
    logic           wr_reg, wr_next;
    logic           ready_reg, ready_next;
    logic           err_reg, err_next;
    logic [31:0]    rdata_reg, rdata_next;
    logic           busy_reg, busy_next;

    logic           mem_we;
    logic [AW-1:0]  rd_idx;
    logic [AW-1:0]  wr_idx;
    logic [31:0]    ram_q;
    logic [31:0]    store_data;
    logic [3:0]     byte_en;
    logic [31:0]    load_val;
    logic [7:0]     byte_sel;
    logic [15:0]    half_sel;

    logic           op_both;
    logic           f3_bad;
    logic           misalign;
    logic           out_of_range;
    logic           access_err;

    // Rejection rules, all evaluated on the latched request.
    assign op_both      = rd_reg & wr_reg;
    assign f3_bad       = rd_reg ? ((f3_reg == 3'b011) || (f3_reg == 3'b110) || (f3_reg == 3'b111))
                                 : (f3_reg >= 3'b011);
    assign misalign     = ((f3_reg[1:0] == 2'b01) && addr_reg[0]) ||
                          ((f3_reg[1:0] == 2'b10) && (addr_reg[1:0] != 2'b00));
    assign out_of_range = (addr_reg[31:2] >= 30'(DEPTH_WORDS));
    assign access_err   = op_both | f3_bad | misalign | out_of_range;

    // The read port follows the live address while idle so the word is already
    // registered when LATENCY=1 jumps straight to RESP; no write can land
    // between that read and the response because only one access is in flight.
    assign rd_idx = (state_reg == IDLE) ? Address[AW+1:2] : addr_reg[AW+1:2];
    assign wr_idx = addr_reg[AW+1:2];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];
            logic [7:0] lane_q_reg;

            // One byte lane: masked write on the response edge, registered read.
            always_ff @(posedge clk) begin
                if (mem_we && byte_en[gi]) begin
                    lane_mem[wr_idx] <= store_data[gi*8 +: 8];
                end
                lane_q_reg <= lane_mem[rd_idx];
            end

            assign ram_q[gi*8 +: 8] = lane_q_reg;
        end
    endgenerate

    // Store lane replication and byte enables from size and low address bits.
    always_comb begin
        store_data = wdata_reg;
        byte_en    = 4'b1111;
        case (f3_reg[1:0])
            2'b00: begin
                store_data = {4{wdata_reg[7:0]}};
                byte_en    = 4'b0001 << addr_reg[1:0];
            end
            2'b01: begin
                store_data = {2{wdata_reg[15:0]}};
                byte_en    = addr_reg[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                store_data = wdata_reg;
                byte_en    = 4'b1111;
            end
        endcase
    end

    // Load lane selection followed by sign or zero extension.
    always_comb begin
        byte_sel = ram_q[7:0];
        case (addr_reg[1:0])
            2'b00:   byte_sel = ram_q[7:0];
            2'b01:   byte_sel = ram_q[15:8];
            2'b10:   byte_sel = ram_q[23:16];
            default: byte_sel = ram_q[31:24];
        endcase
        half_sel = addr_reg[1] ? ram_q[31:16] : ram_q[15:0];
        case (f3_reg)
            3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b010:  load_val = ram_q;
            3'b100:  load_val = {24'b0, byte_sel};
            3'b101:  load_val = {16'b0, half_sel};
            default: load_val = 32'b0;
        endcase
    end

    // State register and registered outputs; reset aborts any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            f3_reg    <= '0;
            rd_reg    <= 1'b0;
            wr_reg    <= 1'b0;
            ready_reg <= 1'b0;
            err_reg   <= 1'b0;
            rdata_reg <= '0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            f3_reg    <= f3_next;
            rd_reg    <= rd_next;
            wr_reg    <= wr_next;
            ready_reg <= ready_next;
            err_reg   <= err_next;
            rdata_reg <= rdata_next;
            busy_reg  <= busy_next;
        end
    end

    // Next-state and output decode: accept, count wait states, respond.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        f3_next    = f3_reg;
        rd_next    = rd_reg;
        wr_next    = wr_reg;
        ready_next = 1'b0;
        err_next   = 1'b0;
        rdata_next = '0;
        busy_next  = busy_reg;
        mem_we     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (MemRead || MemWrite) begin
                    addr_next  = Address;
                    wdata_next = WriteData;
                    f3_next    = Funct3;
                    rd_next    = MemRead;
                    wr_next    = MemWrite;
                    busy_next  = 1'b1;
                    if (LATENCY == 1) begin
                        state_next = RESP;
                        cnt_next   = '0;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CW'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - CW'(1);
                if (cnt_reg == CW'(1)) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                ready_next = 1'b1;
                err_next   = access_err;
                rdata_next = (rd_reg && !access_err) ? load_val : 32'b0;
                mem_we     = wr_reg && !access_err;
                busy_next  = 1'b0;
                cnt_next   = '0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    assign ReadData = rdata_reg;
    assign Ready    = ready_reg;
    assign Err      = err_reg;
    assign Busy     = busy_reg;

endmodule
